// File: rtl/compound_dispatch_pkg.sv
// Shared types for the compound-type dispatcher:
// transaction struct, mode and dispatch-section enums.
package compound_dispatch_types;

  typedef enum logic {
    read  = 1'b0,
    write = 1'b1
  } mode_e;

  typedef struct packed {
    mode_e              mode;
    logic signed [31:0] x;
    logic        [31:0] y;
  } CompoundType;

  typedef enum logic [1:0] {
    SEC_IDLE,
    SEC_UNICAST,
    SEC_BROADCAST
  } Sections;

  localparam CompoundType COMPOUND_RST = '{
    mode: read,
    x:    '0,
    y:    '0
  };

endpackage

// File: rtl/compound_dispatch_if.sv
// Producer/consumer bundle for compound_dispatch:
// one blocking input port, NUM_CH blocking output ports.
interface compound_dispatch_if #(
  parameter int NUM_CH = 4
);
  import compound_dispatch_types::*;

  CompoundType               b_in;
  logic                      b_in_sync;
  logic                      b_in_notify;
  CompoundType [NUM_CH-1:0]  b_out;
  logic        [NUM_CH-1:0]  b_out_sync;
  logic        [NUM_CH-1:0]  b_out_notify;

  modport master (
    output b_in, b_in_sync, b_out_sync,
    input  b_in_notify, b_out, b_out_notify
  );

  modport slave (
    input  b_in, b_in_sync, b_out_sync,
    output b_in_notify, b_out, b_out_notify
  );

endinterface

// File: rtl/compound_fifo.sv
// DEPTH-entry FIFO of CompoundType; pointers wrap
// modulo DEPTH so DEPTH need not be a power of two.
module compound_fifo
  import compound_dispatch_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  CompoundType                  wdata,
  output CompoundType                  rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  CompoundType mem [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push)
        wr_q <= (wr_q == PW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
      if (pop)
        rd_q <= (rd_q == PW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_q] <= wdata;
  end

  assign rdata = mem[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/compound_dispatch.sv
// Buffers compound transactions and dispatches each one
// to a single channel (write) or all channels (read).
module compound_dispatch
  import compound_dispatch_types::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4
) (
  input logic               clk,
  input logic               rst,
  compound_dispatch_if.slave bus
);
  localparam int CHW = $clog2(NUM_CH);
  localparam int CW  = $clog2(DEPTH+1);

  Sections                  sec;
  CompoundType [NUM_CH-1:0] out_q;
  logic        [NUM_CH-1:0] notify_q;
  logic        [NUM_CH-1:0] pend_q;
  logic        [CHW-1:0]    ch_q;
  logic                     in_rdy_q;

  CompoundType              head;
  logic        [CW-1:0]     count;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic        [CHW-1:0]    head_ch;
  logic        [CW:0]       nxt_cnt;
  logic        [NUM_CH-1:0] pend_left;

  assign push      = in_rdy_q & bus.b_in_sync & ~full;
  assign pop       = (sec == SEC_IDLE) & ~empty;
  assign head_ch   = head.x[CHW-1:0];
  assign nxt_cnt   = {1'b0, count} + (CW+1)'(push)
                   - (CW+1)'(pop);
  assign pend_left = pend_q & ~bus.b_out_sync;

  compound_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.b_in),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sec      <= SEC_IDLE;
      out_q    <= {NUM_CH{COMPOUND_RST}};
      notify_q <= '0;
      pend_q   <= '0;
      ch_q     <= '0;
      in_rdy_q <= 1'b1;
    end else begin
      in_rdy_q <= (nxt_cnt < (CW+1)'(DEPTH));
      unique case (sec)
        SEC_IDLE: begin
          if (pop) begin
            if (head.mode == write) begin
              out_q[head_ch]    <= head;
              notify_q[head_ch] <= 1'b1;
              ch_q              <= head_ch;
              sec               <= SEC_UNICAST;
            end else begin
              out_q    <= {NUM_CH{head}};
              notify_q <= '1;
              pend_q   <= '1;
              sec      <= SEC_BROADCAST;
            end
          end
        end
        SEC_UNICAST: begin
          if (bus.b_out_sync[ch_q]) begin
            notify_q[ch_q] <= 1'b0;
            sec            <= SEC_IDLE;
          end
        end
        SEC_BROADCAST: begin
          // each consumer retires independently
          notify_q <= notify_q & ~bus.b_out_sync;
          pend_q   <= pend_left;
          if (pend_left == '0)
            sec <= SEC_IDLE;
        end
        default: sec <= SEC_IDLE;
      endcase
    end
  end

  assign bus.b_out        = out_q;
  assign bus.b_out_notify = notify_q;
  assign bus.b_in_notify  = in_rdy_q;

endmodule

// File: tb/tb_compound_dispatch.sv
// Directed bench for compound_dispatch (NUM_CH=4,
// DEPTH=4): reset, unicast, broadcast, full, reset.
module tb_compound_dispatch;
  import compound_dispatch_types::*;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  compound_dispatch_if #(.NUM_CH(NUM_CH)) bus ();

  compound_dispatch #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic CompoundType ct(input mode_e m,
                                     input int x,
                                     input int y);
    CompoundType c;
    c.mode = m;
    c.x    = x;
    c.y    = y;
    return c;
  endfunction

  task automatic push1(input CompoundType e);
    bus.b_in      = e;
    bus.b_in_sync = 1'b1;
    tick();
    bus.b_in_sync = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.b_in       = COMPOUND_RST;
    bus.b_in_sync  = 1'b0;
    bus.b_out_sync = '0;

    // reset with random inputs
    repeat (2) begin
      bus.b_in.mode  = mode_e'($urandom_range(0, 1));
      bus.b_in.x     = $urandom;
      bus.b_in.y     = $urandom;
      bus.b_in_sync  = 1'($urandom);
      bus.b_out_sync = 4'($urandom);
      tick();
    end
    check("rst_in_notify", bus.b_in_notify, 1'b1);
    check("rst_out_notify", bus.b_out_notify, 4'b0000);
    for (int i = 0; i < NUM_CH; i++)
      check($sformatf("rst_out%0d", i), bus.b_out[i],
            COMPOUND_RST);
    rst            = 1'b0;
    bus.b_in       = COMPOUND_RST;
    bus.b_in_sync  = 1'b0;
    bus.b_out_sync = '0;
    tick();

    // unicast x=6 -> ch2, x=-1 -> ch3
    bus.b_out_sync = '1;
    push1(ct(write, 6, 1));
    check("uc_in_notify", bus.b_in_notify, 1'b1);
    tick();
    check("uc6_notify", bus.b_out_notify, 4'b0100);
    check("uc6_data", bus.b_out[2], ct(write, 6, 1));
    tick();
    check("uc6_done", bus.b_out_notify, 4'b0000);
    push1(ct(write, -1, 2));
    tick();
    check("ucm1_notify", bus.b_out_notify, 4'b1000);
    check("ucm1_data", bus.b_out[3], ct(write, -1, 2));
    tick();
    check("ucm1_done", bus.b_out_notify, 4'b0000);

    // broadcast with staggered consumers
    bus.b_out_sync = '0;
    bus.b_in       = ct(read, 9, 5);
    bus.b_in_sync  = 1'b1;
    tick();
    bus.b_in       = ct(write, 1, 7);
    tick();
    bus.b_in_sync  = 1'b0;
    check("bc_t2", bus.b_out_notify, 4'b1111);
    check("bc_d0", bus.b_out[0], ct(read, 9, 5));
    check("bc_d3", bus.b_out[3], ct(read, 9, 5));
    bus.b_out_sync = 4'b0101;
    tick();
    check("bc_t3", bus.b_out_notify, 4'b1010);
    tick();
    check("bc_t4_ignored", bus.b_out_notify, 4'b1010);
    bus.b_out_sync = 4'b0111;
    tick();
    check("bc_t5", bus.b_out_notify, 4'b1000);
    bus.b_out_sync = 4'b1000;
    tick();
    check("bc_t6", bus.b_out_notify, 4'b0000);
    check("bc_hold", bus.b_out[1], ct(read, 9, 5));
    bus.b_out_sync = '0;
    tick();
    check("bc_next_t7", bus.b_out_notify, 4'b0010);
    check("bc_next_data", bus.b_out[1], ct(write, 1, 7));
    bus.b_out_sync = 4'b0010;
    tick();
    check("bc_next_done", bus.b_out_notify, 4'b0000);

    // fill: first entry parks on ch0, four more fill FIFO
    bus.b_out_sync = '0;
    bus.b_in_sync  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      bus.b_in = ct(write, (k % 2) ? 0 : -4, k);
      check($sformatf("full_rdy%0d", k),
            bus.b_in_notify, 1'b1);
      tick();
    end
    bus.b_in = ct(write, 0, 99);
    check("full_drop", bus.b_in_notify, 1'b0);
    tick();
    check("full_hold", bus.b_in_notify, 1'b0);
    check("full_first_nt", bus.b_out_notify, 4'b0001);
    check("full_first", bus.b_out[0], ct(write, 0, 1));
    bus.b_in_sync  = 1'b0;
    bus.b_out_sync = 4'b0001;
    tick();
    check("full_pop_rdy", bus.b_in_notify, 1'b0);
    check("full_idle_nt", bus.b_out_notify, 4'b0000);
    tick();
    check("full_rise", bus.b_in_notify, 1'b1);
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("order_nt%0d", k),
            bus.b_out_notify, 4'b0001);
      check($sformatf("order%0d", k), bus.b_out[0],
            ct(write, (k % 2) ? 0 : -4, k));
      tick();
      tick();
    end
    check("full_no_extra", bus.b_out_notify, 4'b0000);

    // simultaneous push/pop at count=DEPTH-1
    bus.b_out_sync = '0;
    bus.b_in_sync  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.b_in = ct(write, 0, 10 + k);
      tick();
    end
    bus.b_in_sync = 1'b0;
    check("sp_park", bus.b_out[0], ct(write, 0, 10));
    check("sp_rdy3", bus.b_in_notify, 1'b1);
    bus.b_out_sync = 4'b0001;
    tick();
    bus.b_out_sync = '0;
    bus.b_in       = ct(write, 0, 14);
    bus.b_in_sync  = 1'b1;
    tick();
    check("sp_rdy_keep", bus.b_in_notify, 1'b1);
    check("sp_next_nt", bus.b_out_notify, 4'b0001);
    check("sp_next", bus.b_out[0], ct(write, 0, 11));
    bus.b_in = ct(write, 0, 15);
    tick();
    bus.b_in_sync = 1'b0;
    check("sp_full", bus.b_in_notify, 1'b0);

    // reset mid-broadcast with 3 queued entries
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rb_clean", bus.b_out_notify, 4'b0000);
    bus.b_in      = ct(read, 3, 20);
    bus.b_in_sync = 1'b1;
    tick();
    bus.b_in = ct(write, 0, 21);
    tick();
    bus.b_in       = ct(write, 1, 22);
    bus.b_out_sync = 4'b0011;
    tick();
    bus.b_in       = ct(write, 2, 23);
    bus.b_out_sync = '0;
    tick();
    bus.b_in_sync = 1'b0;
    check("rb_pending", bus.b_out_notify, 4'b1100);
    rst = 1'b1;
    tick();
    check("rb_notify", bus.b_out_notify, 4'b0000);
    check("rb_in_notify", bus.b_in_notify, 1'b1);
    for (int i = 0; i < NUM_CH; i++)
      check($sformatf("rb_out%0d", i), bus.b_out[i],
            COMPOUND_RST);
    rst            = 1'b0;
    bus.b_out_sync = '1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("rb_quiet%0d", c),
            bus.b_out_notify, 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
